// File: rtl/vpu_ub_writeback.sv
// VPU -> unified-buffer writeback stage.
// Takes the four staggered VPU output lanes (lane k trails lane 1 by k-1
// cycles) and realigns them into 4-wide rows. The rows are queued in a small
// FIFO and written to the UB at consecutive addresses over a ready/valid
// handshake. Each start pulse runs one transfer.
//
// Ports:
//   clk, rst (sync, active-low)
//   start, base_addr, num_rows            transfer control (sampled in IDLE)
//   vpu_data_in_1..4, vpu_valid_in_1..4   skewed VPU lanes
//   ub_wr_ready                           UB accepts a write this cycle
//   ub_wr_en, ub_wr_addr, ub_wr_data_1..4 UB write request from the FIFO head
//   busy, done                            transfer status
//   skew_err, overflow_err                sticky error flags, cleared on start
module vpu_ub_writeback #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [DATA_W-1:0] vpu_data_in_1,
    input  logic [DATA_W-1:0] vpu_data_in_2,
    input  logic [DATA_W-1:0] vpu_data_in_3,
    input  logic [DATA_W-1:0] vpu_data_in_4,
    input  logic              vpu_valid_in_1,
    input  logic              vpu_valid_in_2,
    input  logic              vpu_valid_in_3,
    input  logic              vpu_valid_in_4,
    input  logic              ub_wr_ready,
    output logic              ub_wr_en,
    output logic [ADDR_W-1:0] ub_wr_addr,
    output logic [DATA_W-1:0] ub_wr_data_1,
    output logic [DATA_W-1:0] ub_wr_data_2,
    output logic [DATA_W-1:0] ub_wr_data_3,
    output logic [DATA_W-1:0] ub_wr_data_4,
    output logic              busy,
    output logic              done,
    output logic              skew_err,
    output logic              overflow_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Deskew delay lines: lane 1 delayed 3, lane 2 by 2, lane 3 by 1, lane 4 by 0.
    logic [2:0]             r_v1;
    logic [1:0]             r_v2;
    logic                   r_v3;
    logic [2:0][DATA_W-1:0] r_d1;
    logic [1:0][DATA_W-1:0] r_d2;
    logic      [DATA_W-1:0] r_d3;

    // Transfer context
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_num_rows;
    logic [ADDR_W-1:0] r_acc_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_skew_err;
    logic              r_overflow_err;
    logic              r_busy;
    logic              r_done;

    // Aligned-row FIFO; each entry carries its own UB address.
    logic [ADDR_W-1:0]      r_mem_addr [FIFO_DEPTH];
    logic [3:0][DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [3:0]             w_av;
    logic                   w_all_v;
    logic                   w_any_v;
    logic [3:0][DATA_W-1:0] w_row;
    logic                   w_start_acc;
    logic                   w_accept;
    logic                   w_skew;
    logic                   w_nonempty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [ADDR_W-1:0]      w_push_addr;

    // Aligned view of the four lanes (index 0 = lane 1)
    assign w_av    = {vpu_valid_in_4, r_v3, r_v2[1], r_v1[2]};
    assign w_row   = {vpu_data_in_4, r_d3, r_d2[1], r_d1[2]};
    assign w_all_v = &w_av;
    assign w_any_v = |w_av;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_accept    = (r_state == S_RUN) && w_all_v && (r_acc_cnt < r_num_rows);
    assign w_skew      = (r_state == S_RUN) && w_any_v && !w_all_v;

    assign w_nonempty  = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = w_nonempty && ub_wr_ready;
    // A full FIFO still takes the row if the head leaves in the same cycle.
    assign w_push      = w_accept && (!w_full || w_pop);
    assign w_drop      = w_accept && !w_push;
    assign w_push_addr = ADDR_W'(r_base + r_acc_cnt);

    // Delay-line shift registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1 <= '0;
            r_v2 <= '0;
            r_v3 <= 1'b0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else begin
            r_v1 <= {r_v1[1:0], vpu_valid_in_1};
            r_v2 <= {r_v2[0], vpu_valid_in_2};
            r_v3 <= vpu_valid_in_3;
            r_d1 <= {r_d1[1:0], vpu_data_in_1};
            r_d2 <= {r_d2[0], vpu_data_in_2};
            r_d3 <= vpu_data_in_3;
        end
    end

    // FIFO storage; validity is tracked by r_count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_push_addr;
            r_mem_data[r_wr_ptr] <= w_row;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_acc_cnt == r_num_rows) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_wr_cnt == r_num_rows) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, FIFO pointers and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_base         <= '0;
            r_num_rows     <= '0;
            r_acc_cnt      <= '0;
            r_wr_cnt       <= '0;
            r_skew_err     <= 1'b0;
            r_overflow_err <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_start_acc) begin
                r_base         <= base_addr;
                r_num_rows     <= num_rows;
                r_acc_cnt      <= '0;
                r_wr_cnt       <= '0;
                r_skew_err     <= 1'b0;
                r_overflow_err <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc_cnt <= r_acc_cnt + ADDR_W'(1);
                end
                // A dropped row is retired as if written so DRAIN can finish.
                if (w_pop || w_drop) begin
                    r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                end
                if (w_skew) begin
                    r_skew_err <= 1'b1;
                end
                if (w_drop) begin
                    r_overflow_err <= 1'b1;
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write side is the registered FIFO head, forced to zero when empty.
    assign ub_wr_en     = w_nonempty;
    assign ub_wr_addr   = w_nonempty ? r_mem_addr[r_rd_ptr]    : '0;
    assign ub_wr_data_1 = w_nonempty ? r_mem_data[r_rd_ptr][0] : '0;
    assign ub_wr_data_2 = w_nonempty ? r_mem_data[r_rd_ptr][1] : '0;
    assign ub_wr_data_3 = w_nonempty ? r_mem_data[r_rd_ptr][2] : '0;
    assign ub_wr_data_4 = w_nonempty ? r_mem_data[r_rd_ptr][3] : '0;

    assign busy         = r_busy;
    assign done         = r_done;
    assign skew_err     = r_skew_err;
    assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_vpu_ub_writeback.sv
// Bench for vpu_ub_writeback: skewed lane stimulus, queue-level reference
// model of the deskew/FIFO/write stream, scoreboard on every UB write.
module tb_vpu_ub_writeback;

    localparam int MAXC  = 96;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_rows;
    logic [15:0] vpu_data_in_1, vpu_data_in_2, vpu_data_in_3, vpu_data_in_4;
    logic        vpu_valid_in_1, vpu_valid_in_2, vpu_valid_in_3, vpu_valid_in_4;
    logic        ub_wr_ready;
    logic        ub_wr_en;
    logic [7:0]  ub_wr_addr;
    logic [15:0] ub_wr_data_1, ub_wr_data_2, ub_wr_data_3, ub_wr_data_4;
    logic        busy, done, skew_err, overflow_err;

    vpu_ub_writeback #(.DATA_W(16), .ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .num_rows(num_rows),
        .vpu_data_in_1(vpu_data_in_1), .vpu_data_in_2(vpu_data_in_2),
        .vpu_data_in_3(vpu_data_in_3), .vpu_data_in_4(vpu_data_in_4),
        .vpu_valid_in_1(vpu_valid_in_1), .vpu_valid_in_2(vpu_valid_in_2),
        .vpu_valid_in_3(vpu_valid_in_3), .vpu_valid_in_4(vpu_valid_in_4),
        .ub_wr_ready(ub_wr_ready), .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr),
        .ub_wr_data_1(ub_wr_data_1), .ub_wr_data_2(ub_wr_data_2),
        .ub_wr_data_3(ub_wr_data_3), .ub_wr_data_4(ub_wr_data_4),
        .busy(busy), .done(done), .skew_err(skew_err), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    // Per-cycle stimulus schedule; cycle 0 is the start cycle of a run.
    bit          sv   [4][MAXC];
    logic [15:0] sd   [4][MAXC];
    bit          srdy [MAXC];

    wr_t   exp_q[$];
    int    total;
    int    bad;
    string cur;
    int    done_cnt, done_cyc, n_wr, first_wr_cyc;
    logic  [7:0] last_wr_addr;
    bit    m_ovf, m_skew;

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            srdy[c] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                sv[k][c] = 1'b0;
                sd[k][c] = '0;
            end
        end
    endtask

    // Row whose lane 1 is valid at cycle t; lane k follows k-1 cycles later.
    task automatic add_row(input int t, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c3, input logic [15:0] d);
        sv[0][t] = 1'b1; sd[0][t]   = a;
        sv[1][t+1] = 1'b1; sd[1][t+1] = b;
        sv[2][t+2] = 1'b1; sd[2][t+2] = c3;
        sv[3][t+3] = 1'b1; sd[3][t+3] = d;
    endtask

    // Reference: a row appears once all four lanes have arrived; it joins a
    // bounded queue (dropped when full unless the head leaves that cycle); the
    // head is written on any cycle with ready high.
    task automatic model(input logic [7:0] base, input logic [7:0] num, input int n);
        wr_t q[$];
        int  acc;
        bit  pop, full, all1, any1;
        logic [63:0] row;
        exp_q.delete();
        acc = 0; m_ovf = 1'b0; m_skew = 1'b0;
        for (int c = 1; c < n; c++) begin
            all1 = 1'b1; any1 = 1'b0; row = '0;
            for (int k = 0; k < 4; k++) begin
                int src;
                bit v;
                src = c - (3 - k);
                v = (src >= 0) ? sv[k][src] : 1'b0;
                all1 = all1 & v;
                any1 = any1 | v;
                row[63-16*k -: 16] = (src >= 0) ? sd[k][src] : 16'h0;
            end
            full = (q.size() >= DEPTH);
            pop  = (q.size() > 0) && srdy[c];
            if (pop) begin
                wr_t h;
                h = q.pop_front();
                h.cyc = c;
                exp_q.push_back(h);
            end
            if (any1 && !all1 && acc < int'(num)) m_skew = 1'b1;
            if (all1 && acc < int'(num)) begin
                if (!full || pop) begin
                    wr_t e;
                    e.cyc = 0;
                    e.addr = 8'(int'(base) + acc);
                    e.data = row;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
                acc++;
            end
        end
    endtask

    // Drives one transfer for n cycles, scoring writes against exp_q and
    // checking handshake hold and done-time state on the way.
    task automatic run(input logic [7:0] base, input logic [7:0] num, input int n);
        bit          prev_en, prev_rdy, prev_busy;
        logic [7:0]  prev_addr;
        logic [63:0] prev_data, cur_data;
        prev_en = 1'b0; prev_rdy = 1'b0; prev_busy = 1'b0;
        prev_addr = '0; prev_data = '0;
        done_cnt = 0; done_cyc = -1; n_wr = 0; first_wr_cyc = -1; last_wr_addr = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start          = (c == 0);
            base_addr      = base;
            num_rows       = num;
            vpu_valid_in_1 = sv[0][c]; vpu_data_in_1 = sd[0][c];
            vpu_valid_in_2 = sv[1][c]; vpu_data_in_2 = sd[1][c];
            vpu_valid_in_3 = sv[2][c]; vpu_data_in_3 = sd[2][c];
            vpu_valid_in_4 = sv[3][c]; vpu_data_in_4 = sd[3][c];
            ub_wr_ready    = srdy[c];
            @(negedge clk);
            cur_data = {ub_wr_data_1, ub_wr_data_2, ub_wr_data_3, ub_wr_data_4};
            if (prev_en && !prev_rdy) begin
                total++;
                if (ub_wr_en !== 1'b1 || ub_wr_addr !== prev_addr || cur_data !== prev_data) begin
                    bad++;
                    $display("FAIL %s hold c=%0d got en=%b %h/%h want 1 %h/%h", cur, c,
                             ub_wr_en, ub_wr_addr, cur_data, prev_addr, prev_data);
                end
            end
            if (ub_wr_en && ub_wr_ready) begin
                wr_t e;
                n_wr++;
                if (first_wr_cyc < 0) first_wr_cyc = c;
                last_wr_addr = ub_wr_addr;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_write c=%0d got addr=%h want none", cur, c, ub_wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != c || ub_wr_addr !== e.addr || cur_data !== e.data) begin
                        bad++;
                        $display("FAIL %s write got c=%0d %h/%h want c=%0d %h/%h", cur, c,
                                 ub_wr_addr, cur_data, e.cyc, e.addr, e.data);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                total++;
                if (busy !== 1'b0 || ub_wr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_state got busy=%b en=%b want 0 0", cur, busy, ub_wr_en);
                end
                if (num != 8'd0) begin
                    total++;
                    if (prev_busy !== 1'b1) begin
                        bad++;
                        $display("FAIL %s busy_before_done got %b want 1", cur, prev_busy);
                    end
                end
            end
            prev_en = ub_wr_en; prev_rdy = ub_wr_ready; prev_busy = busy;
            prev_addr = ub_wr_addr; prev_data = cur_data;
        end
        @(posedge clk); #1;
        start = 1'b0;
        vpu_valid_in_1 = 1'b0; vpu_valid_in_2 = 1'b0;
        vpu_valid_in_3 = 1'b0; vpu_valid_in_4 = 1'b0;
        ub_wr_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing_writes got %0d left want 0", cur, exp_q.size());
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b0; start = 1'b1; base_addr = 8'h55; num_rows = 8'h3;
        vpu_valid_in_1 = 1'b1; vpu_valid_in_2 = 1'b1; vpu_valid_in_3 = 1'b1; vpu_valid_in_4 = 1'b1;
        vpu_data_in_1 = 16'h1; vpu_data_in_2 = 16'h2; vpu_data_in_3 = 16'h3; vpu_data_in_4 = 16'h4;
        ub_wr_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ub_wr_en, ub_wr_addr, ub_wr_data_1, ub_wr_data_2, ub_wr_data_3, ub_wr_data_4,
             busy, done, skew_err, overflow_err} !== '0) begin
            bad++;
            $display("FAIL %s outputs got en=%b addr=%h busy=%b done=%b se=%b oe=%b want all 0",
                     cur, ub_wr_en, ub_wr_addr, busy, done, skew_err, overflow_err);
        end
        start = 1'b0;
        vpu_valid_in_1 = 1'b0; vpu_valid_in_2 = 1'b0; vpu_valid_in_3 = 1'b0; vpu_valid_in_4 = 1'b0;
        ub_wr_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic();
        cur = "basic";
        clear_sched();
        add_row(1, 16'd1, 16'd2, 16'd3, 16'd4);
        add_row(2, 16'd5, 16'd6, 16'd7, 16'd8);
        add_row(3, 16'd9, 16'd10, 16'd11, 16'd12);
        model(8'h10, 8'd3, 30);
        run(8'h10, 8'd3, 30);
        total++;
        if (first_wr_cyc != 5 || n_wr != 3 || last_wr_addr !== 8'h12) begin
            bad++;
            $display("FAIL %s latency got first=%0d n=%0d last=%h want 5 3 12",
                     cur, first_wr_cyc, n_wr, last_wr_addr);
        end
        total++;
        if (done_cnt != 1 || overflow_err !== 1'b0 || skew_err !== 1'b0) begin
            bad++;
            $display("FAIL %s status got done=%0d oe=%b se=%b want 1 0 0",
                     cur, done_cnt, overflow_err, skew_err);
        end
    endtask

    task automatic test_backpressure();
        cur = "backpressure";
        clear_sched();
        add_row(1, 16'd1, 16'd2, 16'd3, 16'd4);
        add_row(2, 16'd5, 16'd6, 16'd7, 16'd8);
        add_row(3, 16'd9, 16'd10, 16'd11, 16'd12);
        for (int c = 5; c <= 10; c++) srdy[c] = 1'b0;
        model(8'h10, 8'd3, 30);
        run(8'h10, 8'd3, 30);
        total++;
        if (first_wr_cyc != 11 || n_wr != 3 || done_cnt != 1 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL %s result got first=%0d n=%0d done=%0d oe=%b want 11 3 1 0",
                     cur, first_wr_cyc, n_wr, done_cnt, overflow_err);
        end
    endtask

    task automatic test_overflow();
        cur = "overflow";
        clear_sched();
        for (int r = 0; r < 6; r++)
            add_row(1 + r, 16'(4*r+1), 16'(4*r+2), 16'(4*r+3), 16'(4*r+4));
        for (int c = 0; c < 15; c++) srdy[c] = 1'b0;
        model(8'h00, 8'd6, 40);
        run(8'h00, 8'd6, 40);
        total++;
        if (n_wr != 4 || last_wr_addr !== 8'h03 || overflow_err !== 1'b1 || done_cnt != 1) begin
            bad++;
            $display("FAIL %s result got n=%0d last=%h oe=%b done=%0d want 4 03 1 1",
                     cur, n_wr, last_wr_addr, overflow_err, done_cnt);
        end
        total++;
        if (m_ovf !== overflow_err) begin
            bad++;
            $display("FAIL %s model_ovf got %b want %b", cur, overflow_err, m_ovf);
        end
    endtask

    task automatic test_skew();
        cur = "skew";
        clear_sched();
        // row 0 with lane 3 one cycle late
        sv[0][1] = 1'b1; sd[0][1] = 16'hAAA1;
        sv[1][2] = 1'b1; sd[1][2] = 16'hAAA2;
        sv[2][4] = 1'b1; sd[2][4] = 16'hAAA3;
        sv[3][4] = 1'b1; sd[3][4] = 16'hAAA4;
        add_row(8, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        add_row(9, 16'h0505, 16'h0606, 16'h0707, 16'h0808);
        model(8'h20, 8'd2, 30);
        run(8'h20, 8'd2, 30);
        total++;
        if (skew_err !== 1'b1 || n_wr != 2 || last_wr_addr !== 8'h21 || done_cnt != 1) begin
            bad++;
            $display("FAIL %s result got se=%b n=%0d last=%h done=%0d want 1 2 21 1",
                     cur, skew_err, n_wr, last_wr_addr, done_cnt);
        end
    endtask

    task automatic test_wrap_and_zero();
        cur = "wrap";
        clear_sched();
        add_row(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        add_row(2, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        add_row(3, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        model(8'hFE, 8'd3, 30);
        run(8'hFE, 8'd3, 30);
        total++;
        if (n_wr != 3 || last_wr_addr !== 8'h00 || done_cnt != 1) begin
            bad++;
            $display("FAIL %s result got n=%0d last=%h done=%0d want 3 00 1",
                     cur, n_wr, last_wr_addr, done_cnt);
        end
        cur = "zero_rows";
        clear_sched();
        add_row(1, 16'h1, 16'h2, 16'h3, 16'h4);
        model(8'h30, 8'd0, 12);
        run(8'h30, 8'd0, 12);
        total++;
        if (done_cyc != 1 || done_cnt != 1 || n_wr != 0) begin
            bad++;
            $display("FAIL %s result got done_cyc=%0d done=%0d n=%0d want 1 1 0",
                     cur, done_cyc, done_cnt, n_wr);
        end
    endtask

    task automatic test_reset_mid();
        cur = "reset_mid";
        clear_sched();
        add_row(1, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
        add_row(2, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        for (int c = 0; c < MAXC; c++) srdy[c] = 1'b0;
        model(8'h40, 8'd4, 8);
        run(8'h40, 8'd4, 8);
        @(negedge clk);
        total++;
        if (ub_wr_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s pre_reset got en=%b busy=%b want 1 1", cur, ub_wr_en, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ub_wr_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({ub_wr_en, ub_wr_addr, ub_wr_data_1, ub_wr_data_2, ub_wr_data_3, ub_wr_data_4,
             busy, done, skew_err, overflow_err} !== '0) begin
            bad++;
            $display("FAIL %s post_reset got en=%b addr=%h busy=%b done=%b want all 0",
                     cur, ub_wr_en, ub_wr_addr, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ub_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL %s stale_write got en=%b want 0", cur, ub_wr_en);
            end
        end
        cur = "after_reset";
        clear_sched();
        add_row(1, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        add_row(3, 16'h0E0E, 16'h0F0F, 16'h1010, 16'h1111);
        model(8'h50, 8'd2, 25);
        run(8'h50, 8'd2, 25);
        total++;
        if (n_wr != 2 || done_cnt != 1 || overflow_err !== 1'b0 || skew_err !== 1'b0) begin
            bad++;
            $display("FAIL %s result got n=%0d done=%0d oe=%b se=%b want 2 1 0 0",
                     cur, n_wr, done_cnt, overflow_err, skew_err);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] base, num;
            int nrows, t;
            cur = $sformatf("random%0d", it);
            clear_sched();
            base  = 8'($urandom);
            num   = 8'($urandom_range(1, 8));
            nrows = int'(num) + int'($urandom_range(0, 2));
            t = 1 + int'($urandom_range(0, 2));
            for (int r = 0; r < nrows; r++) begin
                add_row(t, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                t += int'($urandom_range(1, 3));
            end
            for (int c = 0; c < 60; c++) srdy[c] = 1'($urandom_range(0, 1));
            model(base, num, 80);
            run(base, num, 80);
            total++;
            if (done_cnt != 1 || overflow_err !== m_ovf || skew_err !== m_skew) begin
                bad++;
                $display("FAIL %s status got done=%0d oe=%b se=%b want 1 %b %b",
                         cur, done_cnt, overflow_err, skew_err, m_ovf, m_skew);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_skew();
        test_wrap_and_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
